hdc_bundle_encoder: RTL and testbench

- Downstream of the quantized level-HV fetch stage: consumes one level hypervector per feature and produces one binary query hypervector per sample.
- Binds each feature by positional permutation and bundles (adds) all features of a sample.
- Permutation is a rotate-by-1 of the accumulator per accepted beat, not a wide barrel shift of the input.
- Majority threshold of the per-bit counts yields the query HV, which feeds the associative-memory / similarity stage.

---
 rtl/hdc_pkg.sv | 8 +
 rtl/hdc_majority.sv | 15 +
 rtl/hdc_bundle_encoder.sv | 61 ++++++
 tb/tb_hdc_bundle_encoder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared hyperdimensional-computing constants, types and encoder states.
package hdc_pkg;
   localparam int HV_DIM   = 4096;
   localparam int M        = 16;
   localparam int NUM_FEAT = 617;
   typedef logic [HV_DIM-1:0] hv_t;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE, OUT} enc_state_t;
endpackage

// File: rtl/hdc_majority.sv
// hdc_majority: binarizes a packed per-bit count vector; a bit is set only when its count
// strictly exceeds NUM_FEAT/2, so even-N ties resolve to 0.
module hdc_majority #(
   parameter int HV_DIM   = hdc_pkg::HV_DIM,
   parameter int NUM_FEAT = hdc_pkg::NUM_FEAT,
   parameter int CW       = $clog2(NUM_FEAT + 1)
) (
   input  logic [HV_DIM*CW-1:0] cnt,
   output logic [HV_DIM-1:0]    hv
);
   localparam logic [CW-1:0] THR = CW'(NUM_FEAT / 2);
   for (genvar i = 0; i < HV_DIM; i++) begin : g_bit
      assign hv[i] = cnt[i*CW +: CW] > THR;
   end
endmodule

// File: rtl/hdc_bundle_encoder.sv
// hdc_bundle_encoder: permutes (rotate-by-1 per beat) and bundles NUM_FEAT level HVs,
// then thresholds the per-bit counts into one binary query HV per sample.
module hdc_bundle_encoder #(
   parameter int HV_DIM   = hdc_pkg::HV_DIM,
   parameter int NUM_FEAT = hdc_pkg::NUM_FEAT,
   localparam int CW      = $clog2(NUM_FEAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [HV_DIM-1:0] level_hv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HV_DIM-1:0] query_hv,
   output logic              busy
);
   import hdc_pkg::*;
   enc_state_t state, next;
   logic [CW-1:0] feat_cnt, feat_nxt;
   logic [CW-1:0] cnt [HV_DIM];
   logic [HV_DIM*CW-1:0] cnt_flat;
   logic [HV_DIM-1:0] maj;
   logic accept, last;
   always_comb begin
      in_ready  = state == IDLE || state == ACCUM;
      out_valid = state == OUT;
      busy      = state != IDLE;
      accept    = in_valid && in_ready;
      feat_nxt  = state == IDLE ? CW'(1) : feat_cnt + CW'(1);
      last      = feat_nxt == CW'(NUM_FEAT);
      next      = state == DONE ? OUT :
                  state == OUT  ? (out_ready ? IDLE : OUT) :
                  accept        ? (last ? DONE : ACCUM) : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         feat_cnt <= '0;
         query_hv <= '0;
      end else begin
         state <= next;
         if (accept) feat_cnt <= feat_nxt;
         if (state == DONE) query_hv <= maj;
      end
   // The first beat of a sample overwrites the counters instead of adding, which clears the old sample.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < HV_DIM; i++) cnt[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < HV_DIM; i++)
            cnt[i] <= (state == ACCUM ? cnt[(i + HV_DIM - 1) % HV_DIM] : CW'(0)) + CW'(level_hv[i]);
      end
   for (genvar i = 0; i < HV_DIM; i++) begin : g_flat
      assign cnt_flat[i*CW +: CW] = cnt[i];
   end
   hdc_majority #(.HV_DIM(HV_DIM), .NUM_FEAT(NUM_FEAT), .CW(CW)) u_maj (
      .cnt (cnt_flat),
      .hv  (maj)
   );
endmodule

// File: tb/tb_hdc_bundle_encoder.sv
// tb_hdc_bundle_encoder: directed checks of the bundle encoder at HV_DIM=16 with
// NUM_FEAT=3 (main instance) and NUM_FEAT=2 (tie-rule instance).
module tb_hdc_bundle_encoder;
   logic clk = 1'b0;
   logic rst;
   logic iv3, ir3, ov3, or3, b3;
   logic [15:0] hv3, q3;
   logic iv2, ir2, ov2, or2, b2;
   logic [15:0] hv2, q2;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hdc_bundle_encoder #(.HV_DIM(16), .NUM_FEAT(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .level_hv(hv3),
      .out_valid(ov3), .out_ready(or3), .query_hv(q3), .busy(b3)
   );
   hdc_bundle_encoder #(.HV_DIM(16), .NUM_FEAT(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .level_hv(hv2),
      .out_valid(ov2), .out_ready(or2), .query_hv(q2), .busy(b2)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat3(input logic [15:0] v);
      iv3 = 1'b1; hv3 = v;
      @(posedge clk); #1;
      iv3 = 1'b0; hv3 = '0;
   endtask

   task automatic beat2(input logic [15:0] v);
      iv2 = 1'b1; hv2 = v;
      @(posedge clk); #1;
      iv2 = 1'b0; hv2 = '0;
   endtask

   // Three back-to-back beats, then latency, result and handshake checks.
   task automatic run3(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] exp);
      beat3(a); beat3(b); beat3(c);
      chk({tag, "_done_ov"}, 16'(ov3), 16'd0);
      chk({tag, "_done_ir"}, 16'(ir3), 16'd0);
      @(posedge clk); #1;
      chk({tag, "_ov"}, 16'(ov3), 16'd1);
      chk({tag, "_q"}, q3, exp);
      or3 = 1'b1;
      @(posedge clk); #1;
      or3 = 1'b0;
      chk({tag, "_post_ov"}, 16'(ov3), 16'd0);
      chk({tag, "_post_ir"}, 16'(ir3), 16'd1);
   endtask

   task automatic run2(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
      beat2(a); beat2(b);
      chk({tag, "_done_ov"}, 16'(ov2), 16'd0);
      @(posedge clk); #1;
      chk({tag, "_ov"}, 16'(ov2), 16'd1);
      chk({tag, "_q"}, q2, exp);
      or2 = 1'b1;
      @(posedge clk); #1;
      or2 = 1'b0;
      chk({tag, "_post_ov"}, 16'(ov2), 16'd0);
   endtask

   initial begin
      rst = 1'b1;
      iv3 = 1'b0; or3 = 1'b0; hv3 = '0;
      iv2 = 1'b0; or2 = 1'b0; hv2 = '0;
      #1;
      chk("rst_ov", 16'(ov3), 16'd0);
      chk("rst_ir", 16'(ir3), 16'd1);
      chk("rst_busy", 16'(b3), 16'd0);
      chk("rst_q", q3, 16'h0000);
      #11 rst = 1'b0;
      @(posedge clk); #1;

      // Reach OUT with a nonzero query, then reset asynchronously mid-cycle.
      beat3(16'hFFFF); beat3(16'hFFFF); beat3(16'hFFFF);
      @(posedge clk); #1;
      chk("pre_arst_q", q3, 16'hFFFF);
      #2 rst = 1'b1;
      #1;
      chk("arst_ov", 16'(ov3), 16'd0);
      chk("arst_q", q3, 16'h0000);
      chk("arst_ir", 16'(ir3), 16'd1);
      chk("arst_busy", 16'(b3), 16'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      run3("rot", 16'h0001, 16'h0002, 16'h0004, 16'h0004);
      run3("sub", 16'h0001, 16'h0001, 16'h0001, 16'h0000);
      run3("sat", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      run3("wrap1", 16'h8000, 16'h0000, 16'h0000, 16'h0000);
      run3("wrap2", 16'h4000, 16'h8000, 16'h0001, 16'h0001);
      run3("wrap3", 16'h8000, 16'h0001, 16'h0001, 16'h0002);

      run2("tie", 16'h0001, 16'h0001, 16'h0000);
      run2("pair", 16'h0001, 16'h0002, 16'h0002);

      // Backpressure: hold out_ready low with a pending upstream beat.
      beat3(16'h0001); beat3(16'h0002); beat3(16'h0004);
      @(posedge clk); #1;
      iv3 = 1'b1; hv3 = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_ir", 16'(ir3), 16'd0);
         chk("bp_ov", 16'(ov3), 16'd1);
         chk("bp_q", q3, 16'h0004);
      end
      or3 = 1'b1;
      @(posedge clk); #1;
      or3 = 1'b0; iv3 = 1'b0; hv3 = '0;
      chk("bp_rel_ov", 16'(ov3), 16'd0);
      chk("bp_rel_ir", 16'(ir3), 16'd1);
      chk("bp_rel_busy", 16'(b3), 16'd0);
      run3("bp_next", 16'h0001, 16'h0001, 16'h0001, 16'h0000);

      // Reset after two beats discards the partial sample.
      beat3(16'hFFFF); beat3(16'hFFFF);
      chk("mid_busy", 16'(b3), 16'd1);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 16'(b3), 16'd0);
      chk("mid_rst_ir", 16'(ir3), 16'd1);
      #2 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("mid_no_ov", 16'(ov3), 16'd0);
      end
      run3("fresh", 16'h4000, 16'h8000, 16'h0001, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
